// File: rtl/segasys1_pkg.sv
// Shared constants and IRQ FSM encoding for the SEGASYS1 sound-command mailbox.
package segasys1_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 2;
  localparam int unsigned IRQGAP_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

endpackage : segasys1_pkg

// File: rtl/segasys1_sndcmd_fifo_if.sv
// Sound-command mailbox bus.
//   master: main-CPU/sound-CPU side (drives CMDWR, CMDDI, SNDRD)
//   slave : mailbox (drives SNDDO, SNDINT, CMDEMPTY, CMDFULL, CMDOVF, CMDCNT)
interface segasys1_sndcmd_fifo_if
  import segasys1_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);

  logic                  CMDWR;
  logic [7:0]            CMDDI;
  logic                  SNDRD;
  logic [7:0]            SNDDO;
  logic                  SNDINT;
  logic                  CMDEMPTY;
  logic                  CMDFULL;
  logic                  CMDOVF;
  logic [DEPTH_LOG2:0]   CMDCNT;

  modport master (
    output CMDWR, CMDDI, SNDRD,
    input  SNDDO, SNDINT, CMDEMPTY, CMDFULL, CMDOVF, CMDCNT
  );

  modport slave (
    input  CMDWR, CMDDI, SNDRD,
    output SNDDO, SNDINT, CMDEMPTY, CMDFULL, CMDOVF, CMDCNT
  );

endinterface : segasys1_sndcmd_fifo_if

// File: rtl/segasys1_strobe_edge.sv
// Registered level-to-pulse detector.
//   clk, rst : clock, synchronous active-high reset
//   level    : strobe level input
//   rise_c   : one-cycle pulse on 0->1 (combinational from level and register)
//   fall_c   : one-cycle pulse on 1->0 (combinational from level and register)
module segasys1_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c,
  output logic fall_c
);

  logic level_q;
  logic level_d;

  assign level_d = level;

  // Cleared in reset so a strobe already high at release reads as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_d;
  end

  assign rise_c = level & ~level_q;
  assign fall_c = ~level & level_q;

endmodule : segasys1_strobe_edge

// File: rtl/segasys1_sndcmd_fifo.sv
// Sound-command mailbox: queues main-CPU command writes and raises SNDINT to
// the sound CPU while commands are pending; each sound-CPU latch read dequeues.
//   CLK48M : sole clock
//   RESET  : synchronous active-high reset
//   bus    : slave side of segasys1_sndcmd_fifo_if (strobes in, data/flags out)
module segasys1_sndcmd_fifo
  import segasys1_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned IRQGAP     = IRQGAP_DEF
) (
  input  logic                   CLK48M,
  input  logic                   RESET,
  segasys1_sndcmd_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned GW    = (IRQGAP > 2) ? $clog2(IRQGAP) : 1;

  logic push_c, pop_c;
  logic wr_fall_c, rd_rise_c;
  logic push_ok_c, pop_ok_c;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          ovf_q, ovf_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [7:0]    snddo_q, snddo_d;

  irq_state_e    state_q;
  logic [GW-1:0] gcnt_q;
  logic          sndint_q;

  // Write strobe acts on its rising edge, read strobe on its falling edge so
  // SNDDO stays stable for the whole read cycle.
  segasys1_strobe_edge u_wr_edge (
    .clk    (CLK48M),
    .rst    (RESET),
    .level  (bus.CMDWR),
    .rise_c (push_c),
    .fall_c (wr_fall_c)
  );

  segasys1_strobe_edge u_rd_edge (
    .clk    (CLK48M),
    .rst    (RESET),
    .level  (bus.SNDRD),
    .rise_c (rd_rise_c),
    .fall_c (pop_c)
  );

  logic unused_edges_c;
  assign unused_edges_c = &{1'b0, wr_fall_c, rd_rise_c};

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a
  // simultaneous pop is still accepted.
  assign pop_ok_c  = pop_c && (cnt_q != '0);
  assign push_ok_c = push_c && ((cnt_q != CW'(DEPTH)) || pop_ok_c);

  // FIFO next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    mem_d  = mem_q;

    if (push_ok_c) begin
      mem_d[wptr_q] = bus.CMDDI;
      wptr_d        = PW'(wptr_q + PW'(1));
    end else if (push_c) begin
      ovf_d = 1'b1;
    end

    if (pop_ok_c) rptr_d = PW'(rptr_q + PW'(1));

    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = CW'(cnt_q + CW'(1));
      2'b01:   cnt_d = CW'(cnt_q - CW'(1));
      default: cnt_d = cnt_q;
    endcase

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(DEPTH));
    snddo_d = empty_d ? 8'h00 : mem_d[rptr_d];
  end

  // FIFO control/status registers
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      snddo_q <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      snddo_q <= snddo_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge CLK48M) begin
    mem_q <= mem_d;
  end

  // IRQ FSM: an accepted pop from any state opens a fresh low gap.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      state_q  <= IDLE;
      gcnt_q   <= '0;
      sndint_q <= 1'b0;
    end else if (pop_ok_c) begin
      state_q  <= GAP;
      gcnt_q   <= GW'(IRQGAP - 1);
      sndint_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_q  <= ASSERT;
            sndint_q <= 1'b1;
          end
        end
        ASSERT: begin
          sndint_q <= 1'b1;
        end
        GAP: begin
          if (gcnt_q == '0) state_q <= IDLE;
          else              gcnt_q  <= GW'(gcnt_q - GW'(1));
        end
        default: begin
          state_q  <= IDLE;
          sndint_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SNDDO    = snddo_q;
  assign bus.SNDINT   = sndint_q;
  assign bus.CMDEMPTY = empty_q;
  assign bus.CMDFULL  = full_q;
  assign bus.CMDOVF   = ovf_q;
  assign bus.CMDCNT   = cnt_q;

endmodule : segasys1_sndcmd_fifo

// File: doc/segasys1_sndcmd_fifo.md
# segasys1_sndcmd_fifo

Sound-command mailbox between the main Z80 and the sound CPU. Main-CPU command writes (the PIO/8255 sound-port write strobe and data) are queued in a small FIFO. An interrupt request is raised to the sound CPU while commands are pending, and each sound-CPU read of the command latch dequeues one entry. This replaces the bare one-shot request/number pair so that back-to-back commands are not lost. It sits between the main-CPU block and the sound-CPU block in the SEGASYS1 top level.

## Interface
- DEPTH_LOG2, default 2: FIFO depth is 2**DEPTH_LOG2 entries (4).
- IRQGAP, default 16: minimum SNDINT low time after a dequeue, in CLK48M cycles.

Ports:
- CLK48M  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMDWR  in  1  main-CPU sound-command write strobe, level, CLK48M-synchronous; each rising edge enqueues one entry.
- CMDDI  in  8  command byte; sampled on the same cycle the CMDWR rising edge is detected.
- SNDRD  in  1  sound-CPU read strobe of the command latch, level; each falling edge dequeues one entry.
- SNDDO  out  8  head-of-FIFO byte; 8'h00 when empty.
- SNDINT  out  1  interrupt request to the sound CPU.
- CMDEMPTY  out  1  FIFO empty.
- CMDFULL  out  1  FIFO full.
- CMDOVF  out  1  sticky overflow flag; cleared only by RESET.
- CMDCNT  out  DEPTH_LOG2+1  current entry count.

## Operation
- Edge detection: one register each for CMDWR and SNDRD.
  - push = CMDWR & ~CMDWR_q.
  - pop = ~SNDRD & SNDRD_q.
  - Popping on the falling edge keeps SNDDO stable for the whole read.
- Storage: 2**DEPTH_LOG2 x 8 register array, write pointer, read pointer, and count. Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Push:
  - Not full, or full with a simultaneous pop: write CMDDI at the write pointer and increment the write pointer.
  - Full without a pop: the byte is dropped, CMDOVF is set, and pointers and count are unchanged.
- Pop:
  - Not empty: increment the read pointer.
  - Empty: ignored, with no state change and no FSM transition.
- Count update: push only +1, pop only −1, both accepted 0.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted.
- Flags: CMDEMPTY = (count == 0), CMDFULL = (count == depth).
- SNDDO = CMDEMPTY ? 8'h00 : mem[read pointer].
- IRQ FSM, with states IDLE, ASSERT, GAP and a counter gcnt:
  - IDLE: go to ASSERT if count != 0.
  - ASSERT: go to GAP on an accepted pop, loading gcnt = IRQGAP−1.
  - GAP: decrement gcnt; go to IDLE when gcnt == 0.
  - An accepted pop in any state enters GAP and reloads gcnt.
  - SNDINT = (state == ASSERT).

## Timing
- Reset values:
  - Pointers, count and CMDOVF are 0.
  - CMDEMPTY = 1, CMDFULL = 0, SNDDO = 8'h00, SNDINT = 0.
  - FSM is in IDLE with gcnt = 0.
  - Edge registers are 0. A strobe already high at reset release counts as a rising edge on the first cycle.
- Push latency: CMDWR first sampled high at edge k → entry stored, and CMDCNT, flags and SNDDO updated, after edge k.
- First interrupt: from an empty FIFO, SNDINT rises after edge k+1.
- Pop: SNDRD first sampled low at edge p → read pointer, count and SNDDO advance, and SNDINT falls, after edge p.
- Interrupt re-arm: with entries remaining, SNDINT is low for exactly IRQGAP+1 cycles (IRQGAP in GAP plus one in IDLE), then rises.
- Strobe width: a strobe held for many cycles generates exactly one push or pop. Strobes must be low, respectively high, for at least one cycle between events.
- Reset mid-operation: all stored entries are discarded and every output returns to its reset value on the next edge.

## Structure
- Shared package segasys1_pkg:
  - IRQ FSM state encoding (IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2).
  - Default DEPTH_LOG2 and IRQGAP constants.
- One sub-module, segasys1_strobe_edge:
  - Registered level → rise/fall pulse detector, synchronous reset.
  - Instantiated once for CMDWR and once for SNDRD.
- The FIFO and FSM stay in the top module.

## Test plan
- Single command: CMDWR pulse with CMDDI = 8'hA5 → CMDCNT = 1, SNDDO = 8'hA5 one cycle after edge; SNDINT high one cycle later. SNDRD pulse → CMDCNT = 0, SNDDO = 8'h00, SNDINT = 0, no re-assert.
- Burst: push 8'h01, 02, 03, 04, then 8'h05 → CMDFULL = 1, CMDOVF = 1, CMDCNT = 4, 8'h05 dropped. Four reads return 01, 02, 03, 04 in order. SNDINT low exactly 17 cycles between each read and the next assert.
- Simultaneous push and pop:
  - Full FIFO: count stays 4, CMDOVF stays 0, and the new byte appears after 3 further pops.
  - Empty FIFO: count becomes 1.
- Pointer wrap: 10 alternating push/pop pairs with bytes 8'h10 to 8'h19 → every read returns the matching byte and CMDCNT never exceeds 1.
- Spurious read: SNDRD pulse while empty → no count change, FSM stays IDLE, SNDINT stays 0.
- Reset mid-operation: 3 entries queued with SNDINT high, RESET asserted for one cycle → all outputs at reset values. A CMDWR held high across the reset release enqueues exactly once.
